// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART register-port scheduler: register map,
// FSM states and the fixed power-up programming sequence.
package uart_sched_pkg;

  // 8250 register map (DLAB-dependent aliases share an address)
  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_DLM = 3'd1;
  localparam logic [2:0] ADDR_IIR = 3'd2;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;
  localparam logic [2:0] ADDR_LSR = 3'd5;
  localparam logic [2:0] ADDR_MSR = 3'd6;
  localparam logic [2:0] ADDR_SCR = 3'd7;

  localparam int         LCR_DLAB_BIT  = 7;
  localparam logic [7:0] LCR_DLAB_MASK = 8'h80;
  localparam logic [7:0] IIR_NO_INT    = 8'h01;
  localparam logic [7:0] MCR_RESET     = 8'h08;
  localparam int         INIT_STEPS    = 5;

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } reg_write_t;

  // One entry of the power-up sequence: open DLAB, load divisor, close DLAB, set FIFOs.
  function automatic reg_write_t init_step(input logic [2:0]  idx,
                                           input logic [15:0] divisor,
                                           input logic [7:0]  lcr,
                                           input logic [7:0]  fcr);
    reg_write_t w;
    case (idx)
      3'd0:    begin w.addr = ADDR_LCR; w.data = lcr | LCR_DLAB_MASK; end
      3'd1:    begin w.addr = ADDR_DLL; w.data = divisor[7:0];        end
      3'd2:    begin w.addr = ADDR_DLM; w.data = divisor[15:8];       end
      3'd3:    begin w.addr = ADDR_LCR; w.data = lcr;                 end
      default: begin w.addr = ADDR_FCR; w.data = fcr;                 end
    endcase
    return w;
  endfunction

  // Registers the UART model cannot read back are answered locally instead.
  function automatic logic is_local_read(input logic [2:0] addr);
    return (addr == ADDR_IIR) || (addr == ADDR_LCR) || (addr == ADDR_MCR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the
// index after the last accepted grant. Requester 0 has priority after reset.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            pos;

  // Pick the first active request at or after the priority pointer, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos[IW-1:0]]) begin
        found                 = 1'b1;
        grant[pos[IW-1:0]]    = 1'b1;
        grant_idx             = pos[IW-1:0];
      end
    end
  end

  // Move priority past the winner only when its grant was actually taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uart_reg_sched.sv
// Front-end for an 8250-style UART register port: programs the UART after
// reset, then shares the port between NREQ requesters round-robin, answering
// IIR/LCR/MCR reads from local shadows.
// Optional feature macro: UART_SCHED_DLAB_GUARD_EN (clears LCR.DLAB on
// requester LCR writes so only the init sequence can open the divisor latch).
module uart_reg_sched
  import uart_sched_pkg::*;
#(
  parameter int          NREQ     = 2,
  parameter logic [15:0] DIVISOR  = 16'h000C,
  parameter logic [7:0]  LCR_INIT = 8'h03,
  parameter logic [7:0]  FCR_INIT = 8'h07
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0][2:0] req_addr,
  input  logic [NREQ-1:0][7:0] req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 init_done,
  output logic                 u_wvalid,
  output logic [2:0]           u_waddr,
  output logic [7:0]           u_wdata,
  output logic                 u_rvalid,
  output logic [2:0]           u_raddr,
  input  logic [7:0]           u_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [2:0]      init_idx;
  reg_write_t      init_cur;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            accept;
  logic            sel_we;
  logic [2:0]      sel_addr;
  logic [7:0]      sel_wdata;
  logic [7:0]      eff_wdata;
  logic [7:0]      local_value;
  logic            cur_we;
  logic [IW-1:0]   cur_idx;
  logic            rsp_from_uart;
  logic [7:0]      local_rdata;
  logic [7:0]      shadow_lcr;
  logic [7:0]      shadow_mcr;

  rr_arbiter #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = (state == IDLE) && (|grant);
  assign sel_we    = req_we[grant_idx];
  assign sel_addr  = req_addr[grant_idx];
  assign sel_wdata = req_wdata[grant_idx];
  assign rsp_rdata = (|rsp_valid) ? (rsp_from_uart ? u_rdata : local_rdata) : 8'h00;

  // Current power-up write, selected by the init step counter.
  always_comb begin
    init_cur = init_step(init_idx, DIVISOR, LCR_INIT, FCR_INIT);
  end

  // Write data as it will reach the UART and the shadows.
  always_comb begin
    eff_wdata = sel_wdata;
`ifdef UART_SCHED_DLAB_GUARD_EN
    if (sel_addr == ADDR_LCR) eff_wdata[LCR_DLAB_BIT] = 1'b0;
`else
`endif
  end

  // Value returned for reads the UART cannot serve.
  always_comb begin
    local_value = 8'h00;
    case (sel_addr)
      ADDR_IIR: local_value = IIR_NO_INT;
      ADDR_LCR: local_value = shadow_lcr;
      ADDR_MCR: local_value = shadow_mcr;
      default:  local_value = 8'h00;
    endcase
  end

  // Main sequencer: init writes, then one arbitrated access at a time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= INIT;
      init_idx      <= '0;
      init_done     <= 1'b0;
      u_wvalid      <= 1'b0;
      u_waddr       <= '0;
      u_wdata       <= '0;
      u_rvalid      <= 1'b0;
      u_raddr       <= '0;
      rsp_valid     <= '0;
      rsp_from_uart <= 1'b0;
      local_rdata   <= '0;
      cur_we        <= 1'b0;
      cur_idx       <= '0;
      shadow_lcr    <= 8'h00;
      shadow_mcr    <= MCR_RESET;
    end else begin
      case (state)
        INIT: begin
          if (init_idx == 3'(INIT_STEPS)) begin
            u_wvalid  <= 1'b0;
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            u_wvalid <= 1'b1;
            u_waddr  <= init_cur.addr;
            u_wdata  <= init_cur.data;
            if (init_cur.addr == ADDR_LCR) shadow_lcr <= init_cur.data;
            init_idx <= init_idx + 3'd1;
          end
        end
        IDLE: begin
          u_wvalid  <= 1'b0;
          u_rvalid  <= 1'b0;
          rsp_valid <= '0;
          if (accept) begin
            cur_we  <= sel_we;
            cur_idx <= grant_idx;
            state   <= ISSUE;
            if (sel_we) begin
              u_wvalid <= 1'b1;
              u_waddr  <= sel_addr;
              u_wdata  <= eff_wdata;
              if (sel_addr == ADDR_LCR) shadow_lcr <= eff_wdata;
              if (sel_addr == ADDR_MCR) shadow_mcr <= eff_wdata;
            end else if (is_local_read(sel_addr)) begin
              rsp_from_uart <= 1'b0;
              local_rdata   <= local_value;
            end else begin
              u_rvalid      <= 1'b1;
              u_raddr       <= sel_addr;
              rsp_from_uart <= 1'b1;
            end
          end
        end
        ISSUE: begin
          u_wvalid <= 1'b0;
          u_rvalid <= 1'b0;
          if (cur_we) begin
            state <= IDLE;
          end else begin
            rsp_valid <= NREQ'(1) << cur_idx;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_sched.sv
// Self-checking bench for uart_reg_sched: directed and randomized accesses
// against a register-level reference of what each requester should observe.
// Honours UART_SCHED_DLAB_GUARD_EN the same way the design does.
module tb_uart_reg_sched;

  localparam int          NREQ     = 2;
  localparam logic [15:0] DIVISOR  = 16'h000C;
  localparam logic [7:0]  LCR_INIT = 8'h03;
  localparam logic [7:0]  FCR_INIT = 8'h07;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_we;
  logic [NREQ-1:0][2:0] req_addr;
  logic [NREQ-1:0][7:0] req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 init_done;
  logic                 u_wvalid;
  logic [2:0]           u_waddr;
  logic [7:0]           u_wdata;
  logic                 u_rvalid;
  logic [2:0]           u_raddr;
  logic [7:0]           u_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the scheduler's shadows and the UART scratch hold.
  logic [7:0] m_lcr;
  logic [7:0] m_mcr;
  logic [7:0] m_scr;
  int         m_last;

  typedef struct {
    int         r;
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    int         w;
    logic [7:0] exp;
  } op_t;

  uart_reg_sched #(
    .NREQ    (NREQ),
    .DIVISOR (DIVISOR),
    .LCR_INIT(LCR_INIT),
    .FCR_INIT(FCR_INIT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .u_wvalid (u_wvalid),
    .u_waddr  (u_waddr),
    .u_wdata  (u_wdata),
    .u_rvalid (u_rvalid),
    .u_raddr  (u_raddr),
    .u_rdata  (u_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal UART: register file with a fixed idle LSR, read data one cycle late.
  logic [7:0] uart_regs [8];
  always @(posedge clk) begin
    if (u_wvalid) uart_regs[u_waddr] <= u_wdata;
    if (u_rvalid) u_rdata <= (u_raddr == 3'd5) ? 8'h60 : uart_regs[u_raddr];
  end

  function automatic logic [7:0] guarded(input logic [2:0] a, input logic [7:0] d);
`ifdef UART_SCHED_DLAB_GUARD_EN
    if (a == 3'd3) return d & 8'h7F;
`endif
    return d;
  endfunction

  function automatic logic uart_read(input logic [2:0] a);
    return !(a == 3'd2 || a == 3'd3 || a == 3'd4);
  endfunction

  // Drive one request from requester r and capture what the DUT does with it.
  task automatic access(input int r, input logic we, input logic [2:0] a, input logic [7:0] d,
                        output int waits, output logic wv, output logic [2:0] wa,
                        output logic [7:0] wdo, output logic rv, output logic [2:0] ra,
                        output logic [1:0] rspv, output logic [7:0] rd);
    req_we[r] = we; req_addr[r] = a; req_wdata[r] = d; req_valid[r] = 1'b1;
    waits = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (req_ready[r] === 1'b1) begin waits = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    wv = u_wvalid; wa = u_waddr; wdo = u_wdata; rv = u_rvalid; ra = u_raddr;
    @(posedge clk); #1;
    rspv = rsp_valid; rd = rsp_rdata;
    m_last = r;
  endtask

  task automatic test_reset();
    logic [2:0] ea [5];
    logic [7:0] ed [5];
    ea = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2};
    ed = '{LCR_INIT | 8'h80, DIVISOR[7:0], DIVISOR[15:8], LCR_INIT, FCR_INIT};
    rstn = 1'b0; req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({u_wvalid, u_rvalid, init_done, rsp_valid, u_waddr, u_wdata} !== 15'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got %h expected 0", {u_wvalid, u_rvalid, init_done, rsp_valid, u_waddr, u_wdata});
    end
    rstn = 1'b1; req_valid = 2'b11; req_we = '0;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL init_ready cycle0 got %b expected 00", req_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({u_wvalid, u_waddr, u_wdata, init_done, req_ready} !== {1'b1, ea[k], ed[k], 1'b0, 2'b00}) begin
        n_fail++;
        $display("[TB] FAIL init_write[%0d] got v=%b a=%0d d=%h done=%b rdy=%b expected v=1 a=%0d d=%h done=0 rdy=00",
                 k, u_wvalid, u_waddr, u_wdata, init_done, req_ready, ea[k], ed[k]);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({init_done, u_wvalid, req_ready} !== 4'b1001) begin
      n_fail++;
      $display("[TB] FAIL init_end got done=%b wv=%b rdy=%b expected done=1 wv=0 rdy=01", init_done, u_wvalid, req_ready);
    end
    req_valid = '0;
    m_lcr = LCR_INIT; m_mcr = 8'h08; m_last = NREQ - 1;
  endtask

  task automatic test_directed();
    op_t ops [9];
    int waits; logic wv, rv; logic [2:0] wa, ra; logic [7:0] wdo, rd; logic [1:0] rspv, ersp;
    ops[0] = '{0, 1'b1, 3'd7, 8'hA5, 0, 8'hA5};
    ops[1] = '{0, 1'b0, 3'd7, 8'h00, 0, 8'hA5};
    ops[2] = '{1, 1'b0, 3'd5, 8'h00, 1, 8'h60};
    ops[3] = '{1, 1'b0, 3'd2, 8'h00, 1, 8'h01};
    ops[4] = '{1, 1'b0, 3'd4, 8'h00, 1, 8'h08};
    ops[5] = '{0, 1'b1, 3'd3, 8'h83, 1, guarded(3'd3, 8'h83)};
    ops[6] = '{0, 1'b0, 3'd3, 8'h00, 0, guarded(3'd3, 8'h83)};
    ops[7] = '{1, 1'b1, 3'd4, 8'h5A, 1, 8'h5A};
    ops[8] = '{1, 1'b0, 3'd4, 8'h00, 0, 8'h5A};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      access(ops[i].r, ops[i].we, ops[i].a, ops[i].d, waits, wv, wa, wdo, rv, ra, rspv, rd);
      n_checks++;
      if (waits !== ops[i].w) begin n_fail++; $display("[TB] FAIL directed[%0d] accept_delay got %0d expected %0d", i, waits, ops[i].w); end
      if (ops[i].we) begin
        n_checks++;
        if ({wv, wa, wdo, rv, rspv} !== {1'b1, ops[i].a, ops[i].exp, 1'b0, 2'b00}) begin
          n_fail++;
          $display("[TB] FAIL directed[%0d] write got wv=%b a=%0d d=%h rv=%b rsp=%b expected wv=1 a=%0d d=%h rv=0 rsp=00",
                   i, wv, wa, wdo, rv, rspv, ops[i].a, ops[i].exp);
        end
      end else begin
        ersp = '0; ersp[ops[i].r] = 1'b1;
        n_checks++;
        if ({wv, rv, rspv, rd} !== {1'b0, uart_read(ops[i].a), ersp, ops[i].exp}) begin
          n_fail++;
          $display("[TB] FAIL directed[%0d] read got wv=%b rv=%b rsp=%b d=%h expected wv=0 rv=%b rsp=%b d=%h",
                   i, wv, rv, rspv, rd, uart_read(ops[i].a), ersp, ops[i].exp);
        end
        if (uart_read(ops[i].a)) begin
          n_checks++;
          if (ra !== ops[i].a) begin n_fail++; $display("[TB] FAIL directed[%0d] raddr got %0d expected %0d", i, ra, ops[i].a); end
        end
      end
    end
    m_scr = 8'hA5; m_lcr = guarded(3'd3, 8'h83); m_mcr = 8'h5A;
  endtask

  task automatic test_back_to_back();
    int exp_g, n_acc, last_cyc;
    logic [1:0] acc;
    logic [7:0] data [2];
    data = '{8'h11, 8'h22};
    repeat (2) @(posedge clk);
    #1;
    exp_g = (m_last + 1) % NREQ; n_acc = 0; last_cyc = -10;
    req_we = 2'b11; req_addr[0] = 3'd7; req_addr[1] = 3'd7;
    req_wdata[0] = data[0]; req_wdata[1] = data[1]; req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        n_checks++;
        if (acc !== (2'b01 << exp_g)) begin n_fail++; $display("[TB] FAIL b2b_grant cycle %0d got %b expected %b", c, acc, 2'b01 << exp_g); end
        if (n_acc > 0) begin
          n_checks++;
          if (c - last_cyc !== 2) begin n_fail++; $display("[TB] FAIL b2b_spacing got %0d expected 2", c - last_cyc); end
        end
        m_scr = data[exp_g]; m_last = exp_g;
        exp_g = (exp_g + 1) % NREQ; n_acc++; last_cyc = c;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    n_checks++;
    if (n_acc !== 4) begin n_fail++; $display("[TB] FAIL b2b_accept_count got %0d expected 4", n_acc); end
  endtask

  task automatic test_random();
    int waits, r, ew; logic we, wv, rv, prev_read; logic [2:0] a, wa, ra; logic [7:0] d, wdo, rd, ev;
    logic [1:0] rspv, ersp;
    logic [2:0] wr_addrs [3];
    logic [2:0] rd_addrs [5];
    wr_addrs = '{3'd3, 3'd4, 3'd7};
    rd_addrs = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    repeat (2) @(posedge clk);
    #1;
    prev_read = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, NREQ - 1)); we = 1'($urandom_range(0, 1)); d = 8'($urandom);
      a = we ? wr_addrs[$urandom_range(0, 2)] : rd_addrs[$urandom_range(0, 4)];
      ew = prev_read ? 1 : 0;
      access(r, we, a, d, waits, wv, wa, wdo, rv, ra, rspv, rd);
      n_checks++;
      if (waits !== ew) begin n_fail++; $display("[TB] FAIL random[%0d] accept_delay got %0d expected %0d", i, waits, ew); end
      if (we) begin
        ev = guarded(a, d);
        if (a == 3'd3) m_lcr = ev;
        if (a == 3'd4) m_mcr = ev;
        if (a == 3'd7) m_scr = ev;
        n_checks++;
        if ({wv, wa, wdo, rv, rspv} !== {1'b1, a, ev, 1'b0, 2'b00}) begin
          n_fail++;
          $display("[TB] FAIL random[%0d] write got wv=%b a=%0d d=%h rv=%b rsp=%b expected wv=1 a=%0d d=%h rv=0 rsp=00",
                   i, wv, wa, wdo, rv, rspv, a, ev);
        end
      end else begin
        case (a)
          3'd2:    ev = 8'h01;
          3'd3:    ev = m_lcr;
          3'd4:    ev = m_mcr;
          3'd5:    ev = 8'h60;
          default: ev = m_scr;
        endcase
        ersp = '0; ersp[r] = 1'b1;
        n_checks++;
        if ({wv, rv, rspv, rd} !== {1'b0, uart_read(a), ersp, ev}) begin
          n_fail++;
          $display("[TB] FAIL random[%0d] read a=%0d got wv=%b rv=%b rsp=%b d=%h expected wv=0 rv=%b rsp=%b d=%h",
                   i, a, wv, rv, rspv, rd, uart_read(a), ersp, ev);
        end
      end
      prev_read = !we;
    end
  endtask

  task automatic test_reset_mid();
    int waits; logic wv, rv, saw; logic [2:0] wa, ra; logic [7:0] wdo, rd; logic [1:0] rspv;
    repeat (2) @(posedge clk);
    #1;
    req_we[0] = 1'b0; req_addr[0] = 3'd5; req_valid[0] = 1'b1; waits = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (req_ready[0] === 1'b1) begin waits = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    n_checks++;
    if ({waits == 0, u_rvalid} !== 2'b11) begin n_fail++; $display("[TB] FAIL midrst_issue got delay=%0d rv=%b expected delay=0 rv=1", waits, u_rvalid); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({u_rvalid, rsp_valid} !== 3'b000) begin n_fail++; $display("[TB] FAIL midrst_async got rv=%b rsp=%b expected 0/00", u_rvalid, rsp_valid); end
    saw = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (rsp_valid !== 2'b00) saw = 1'b1; end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rsp_dropped got %b expected 0", saw); end
    rstn = 1'b1; req_valid = 2'b11;
    @(posedge clk); #1;
    n_checks++;
    if ({u_wvalid, u_waddr, u_wdata} !== {1'b1, 3'd3, LCR_INIT | 8'h80}) begin
      n_fail++;
      $display("[TB] FAIL midrst_init_restart got v=%b a=%0d d=%h expected v=1 a=3 d=%h", u_wvalid, u_waddr, u_wdata, LCR_INIT | 8'h80);
    end
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    n_checks++;
    if ({init_done, req_ready} !== 3'b101) begin n_fail++; $display("[TB] FAIL midrst_ptr_reset got done=%b rdy=%b expected done=1 rdy=01", init_done, req_ready); end
    req_valid = '0;
    access(0, 1'b0, 3'd3, 8'h00, waits, wv, wa, wdo, rv, ra, rspv, rd);
    n_checks++;
    if ({rv, rspv, rd} !== {1'b0, 2'b01, LCR_INIT}) begin n_fail++; $display("[TB] FAIL midrst_lcr_shadow got rv=%b rsp=%b d=%h expected rv=0 rsp=01 d=%h", rv, rspv, rd, LCR_INIT); end
    access(1, 1'b0, 3'd4, 8'h00, waits, wv, wa, wdo, rv, ra, rspv, rd);
    n_checks++;
    if ({rv, rspv, rd} !== {1'b0, 2'b10, 8'h08}) begin n_fail++; $display("[TB] FAIL midrst_mcr_shadow got rv=%b rsp=%b d=%h expected rv=0 rsp=10 d=08", rv, rspv, rd); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rstn = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    m_lcr = 8'h00; m_mcr = 8'h08; m_scr = 8'h00; m_last = NREQ - 1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
